// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the shared-ALU arbiter slice.
package alu_arb_pkg;

  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_XOR = 3'b011;
  localparam logic [OPW-1:0] OP_SUB = 3'b100;
  localparam logic [OPW-1:0] OP_SRL = 3'b101;
  localparam logic [OPW-1:0] OP_SLL = 3'b110;
  localparam logic [OPW-1:0] OP_NOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu32.sv
// 32-bit combinational ALU; shift amount is B[4:0], add/sub wrap mod 2^32.
module alu32
  import alu_arb_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  S,
  output logic [31:0] R
);

  // Operation select
  always_comb begin
    R = '0;
    case (S)
      OP_AND: R = A & B;
      OP_OR:  R = A | B;
      OP_ADD: R = A + B;
      OP_XOR: R = A ^ B;
      OP_SUB: R = A - B;
      OP_SRL: R = A >> B[4:0];
      OP_SLL: R = A << B[4:0];
      OP_NOR: R = ~(A | B);
      default: R = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb_rr.sv
// Two-requester round-robin grant: a lone requester wins, a tie goes to prio.
module alu_arb_rr (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = '0;
    if (valid[0] && (!valid[1] || !prio)) grant[0] = 1'b1;
    if (valid[1] && (!valid[0] ||  prio)) grant[1] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu32 between two valid/ready requesters with round-robin
// arbitration. Optional registered zero flag under `ALU_ZERO_FLAG_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req_op0,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_b0,
  input  logic [OPW-1:0] req_op1,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic           busy
`ifdef ALU_ZERO_FLAG_EN
  , output logic         zero
`endif
);

  arb_state_t     state_q, state_d;
  logic           prio_q;
  logic           gnt_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [W-1:0]   alu_r;
  logic [1:0]     grant;
  logic           accept;
  logic           rsp_fire;

  alu_arb_rr u_rr (
    .valid (req_valid),
    .prio  (prio_q),
    .grant (grant)
  );

  alu32 u_alu (
    .A (a_q),
    .B (b_q),
    .S (op_q),
    .R (alu_r)
  );

  // Next-state and handshake decode; the unused encoding 2'd3 behaves as IDLE
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        // ready is combinational from req_valid, so mask it while in reset
        req_ready = rst_n ? grant : '0;
        accept    = |(req_valid & grant);
        if (accept) state_d = ST_EXEC;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand latch on accept, result capture in EXEC, priority swap on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      prio_q <= 1'b0;
    end else begin
      if (accept) begin
        gnt_q <= grant[1];
        op_q  <= grant[1] ? req_op1 : req_op0;
        a_q   <= grant[1] ? req_a1  : req_a0;
        b_q   <= grant[1] ? req_b1  : req_b0;
      end
      if (state_q == ST_EXEC) res_q <= alu_r;
      if (rsp_fire) prio_q <= ~gnt_q;
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag captured alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  zero_q <= 1'b0;
    else if (state_q == ST_EXEC) zero_q <= (alu_r == '0);
  end

  assign zero = zero_q;
`endif

  assign rsp_data = res_q;
  assign busy     = (state_q == ST_EXEC) || (state_q == ST_RESP);

endmodule
